// File: rtl/oto_pilot_pkg.sv
// Shared definitions for oto_pilot and its plant emulator: state encoding
// and default word widths of the pad interface.
package oto_pilot_pkg;

   localparam int ALT_W_DEF  = 10;
   localparam int GNSS_W_DEF = 10;
   localparam int TGT_W_DEF  = 7;

   typedef enum logic [1:0] {
      ST_IDLE   = 2'd0,
      ST_GROUND = 2'd1,
      ST_FLYING = 2'd2
   } plant_state_t;

endpackage

// File: rtl/plant_tick_gen.sv
// Plant update prescaler: counts 0..UPDATE_DIV-1 while running and emits a
// one-cycle tick on the terminal count. clear forces the count back to zero.
module plant_tick_gen #(
   parameter int UPDATE_DIV = 1000
) (
   input  logic clk,
   input  logic rst,
   input  logic clear,
   input  logic run,
   output logic tick
);

   localparam int CNT_W = $clog2(UPDATE_DIV);
   localparam logic [CNT_W-1:0] LAST = CNT_W'(UPDATE_DIV - 1);

   logic [CNT_W-1:0] count;

   // A clear in the same cycle as the terminal count suppresses the tick.
   assign tick = run && !clear && (count == LAST);

   // NOTE: sequential state uses non-blocking assignments so every register
   // samples the pre-edge values, independent of statement order.
   always_ff @(posedge clk) begin
      if (rst || clear) begin
         count <= '0;
      end else if (run) begin
         count <= (count == LAST) ? '0 : count + CNT_W'(1);
      end
   end

endmodule

// File: rtl/oto_pilot_plant_model.sv
// Closed-loop flight-plant emulator driving oto_pilot's altimeter, GNSS and
// target inputs from its motor command; altitude saturates at ground/ceiling.
module oto_pilot_plant_model
   import oto_pilot_pkg::*;
#(
   parameter int ALT_W      = ALT_W_DEF,
   parameter int GNSS_W     = GNSS_W_DEF,
   parameter int TGT_W      = TGT_W_DEF,
   parameter int CLIMB_STEP = 2,
   parameter int SINK_STEP  = 1,
   parameter int UPDATE_DIV = 1000
) (
   input  logic              clk,
   input  logic              rst,
   input  logic              enable_i,
   input  logic              load_i,
   input  logic [ALT_W-1:0]  init_alt_i,
   input  logic [TGT_W-1:0]  target_i,
   input  logic              motor_i,
   output logic [ALT_W-1:0]  altimetre_o,
   output logic [GNSS_W-1:0] gnss_o,
   output logic [TGT_W-1:0]  hedef_yukseklik_o,
   output logic              yukseklik_bilgisi_o,
   output logic              airborne_o
);

   localparam logic [ALT_W:0]   CLIMB_EXT = (ALT_W + 1)'(CLIMB_STEP);
   localparam logic [ALT_W-1:0] SINK_V    = ALT_W'(SINK_STEP);

   plant_state_t     state;
   logic             tick;
   logic             tick_clear;
   logic [ALT_W:0]   climb_sum;
   logic [ALT_W-1:0] climb_sat;
   logic [ALT_W-1:0] sink_val;

   // Load and disable both restart the prescaler and discard a pending tick.
   assign tick_clear = load_i || !enable_i || (state == ST_IDLE);

   plant_tick_gen #(
      .UPDATE_DIV(UPDATE_DIV)
   ) u_tick_gen (
      .clk   (clk),
      .rst   (rst),
      .clear (tick_clear),
      .run   (state != ST_IDLE),
      .tick  (tick)
   );

   // One extra bit catches the carry so the ceiling clamps instead of wrapping.
   assign climb_sum = {1'b0, altimetre_o} + CLIMB_EXT;
   assign climb_sat = climb_sum[ALT_W] ? '1 : climb_sum[ALT_W-1:0];
   assign sink_val  = (altimetre_o < SINK_V) ? '0 : altimetre_o - SINK_V;

   assign airborne_o = (state == ST_FLYING);

   always_ff @(posedge clk) begin
      if (rst) begin
         state               <= ST_IDLE;
         altimetre_o         <= '0;
         gnss_o              <= '0;
         hedef_yukseklik_o   <= '0;
         yukseklik_bilgisi_o <= 1'b0;
      end else begin
         yukseklik_bilgisi_o <= 1'b0;
         if (load_i) begin
            altimetre_o       <= init_alt_i;
            hedef_yukseklik_o <= target_i;
            gnss_o            <= '0;
            if (!enable_i)             state <= ST_IDLE;
            else if (init_alt_i == '0) state <= ST_GROUND;
            else                       state <= ST_FLYING;
         end else if (!enable_i) begin
            state <= ST_IDLE;
         end else begin
            unique case (state)
               ST_IDLE: begin
                  state <= (altimetre_o == '0) ? ST_GROUND : ST_FLYING;
               end
               ST_GROUND: begin
                  if (tick) begin
                     yukseklik_bilgisi_o <= 1'b1;
                     if (motor_i) begin
                        altimetre_o <= climb_sat;
                        state       <= ST_FLYING;
                     end
                  end
               end
               ST_FLYING: begin
                  if (tick) begin
                     yukseklik_bilgisi_o <= 1'b1;
                     gnss_o              <= gnss_o + GNSS_W'(1);
                     if (motor_i) begin
                        altimetre_o <= climb_sat;
                     end else begin
                        altimetre_o <= sink_val;
                        if (sink_val == '0) state <= ST_GROUND;
                     end
                  end
               end
               default: state <= ST_IDLE;
            endcase
         end
      end
   end

endmodule

// File: tb/tb_oto_pilot_plant_model.sv
// Self-checking bench for oto_pilot_plant_model with a fast prescaler:
// table of load/fly vectors plus hand-written latency and override sequences.
module tb_oto_pilot_plant_model;

   localparam int DIV = 4;

   logic       clk = 1'b0;
   logic       rst;
   logic       enable_i;
   logic       load_i;
   logic [9:0] init_alt_i;
   logic [6:0] target_i;
   logic       motor_i;
   logic [9:0] altimetre_o;
   logic [9:0] gnss_o;
   logic [6:0] hedef_yukseklik_o;
   logic       yukseklik_bilgisi_o;
   logic       airborne_o;

   int checks   = 0;
   int failures = 0;

   typedef struct packed {
      logic [9:0] alt;
      logic [9:0] gnss;
      logic       air;
   } exp_t;

   typedef struct packed {
      logic [9:0]       init_alt;
      logic [6:0]       target;
      logic             motor;
      logic [2:0][9:0]  exp_alt;
      logic [2:0][9:0]  exp_gnss;
      logic [2:0]       exp_air;
   } vec_t;

   exp_t sb[$];
   vec_t vecs[5];

   oto_pilot_plant_model #(
      .ALT_W(10), .GNSS_W(10), .TGT_W(7),
      .CLIMB_STEP(2), .SINK_STEP(1), .UPDATE_DIV(DIV)
   ) dut (
      .clk                 (clk),
      .rst                 (rst),
      .enable_i            (enable_i),
      .load_i              (load_i),
      .init_alt_i          (init_alt_i),
      .target_i            (target_i),
      .motor_i             (motor_i),
      .altimetre_o         (altimetre_o),
      .gnss_o              (gnss_o),
      .hedef_yukseklik_o   (hedef_yukseklik_o),
      .yukseklik_bilgisi_o (yukseklik_bilgisi_o),
      .airborne_o          (airborne_o)
   );

   always #5 clk = ~clk;

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         failures++;
         $display("FAIL %s: actual=%0d required=%0d", name, act, exp);
      end
   endtask

   function automatic vec_t make_vec(input int init, input int tgt, input bit m,
                                     input int a0, input int a1, input int a2,
                                     input int g0, input int g1, input int g2,
                                     input bit r0, input bit r1, input bit r2);
      vec_t v;
      v.init_alt    = 10'(init);
      v.target      = 7'(tgt);
      v.motor       = m;
      v.exp_alt[0]  = 10'(a0);
      v.exp_alt[1]  = 10'(a1);
      v.exp_alt[2]  = 10'(a2);
      v.exp_gnss[0] = 10'(g0);
      v.exp_gnss[1] = 10'(g1);
      v.exp_gnss[2] = 10'(g2);
      v.exp_air     = {r2, r1, r0};
      return v;
   endfunction

   function automatic exp_t mk(input int a, input int g, input bit r);
      exp_t e;
      e.alt  = 10'(a);
      e.gnss = 10'(g);
      e.air  = r;
      return e;
   endfunction

   // Every strobe must match the oldest outstanding expected sample.
   always @(negedge clk) begin
      if (yukseklik_bilgisi_o === 1'b1) begin
         exp_t e;
         check("strobe_expected", 32'(sb.size() > 0), 32'd1);
         if (sb.size() > 0) begin
            e = sb.pop_front();
            check("sample_alt",  32'(altimetre_o), 32'(e.alt));
            check("sample_gnss", 32'(gnss_o),      32'(e.gnss));
            check("sample_air",  32'(airborne_o),  32'(e.air));
         end
      end
   end

   task automatic wait_strobe(input string name, output int n);
      n = 0;
      do begin
         @(negedge clk);
         n++;
      end while (yukseklik_bilgisi_o !== 1'b1 && n < 20);
      check({name, "_seen"}, 32'(yukseklik_bilgisi_o), 32'd1);
   endtask

   task automatic do_load(input int init, input int tgt, input bit m);
      load_i     = 1'b1;
      init_alt_i = 10'(init);
      target_i   = 7'(tgt);
      motor_i    = m;
      @(negedge clk);
      load_i = 1'b0;
   endtask

   initial begin
      int n;

      vecs[0] = make_vec(1020, 55, 1'b1, 1022, 1023, 1023, 1, 2, 3, 1, 1, 1);
      vecs[1] = make_vec(2,    20, 1'b0, 1,    0,    0,    1, 2, 2, 1, 0, 0);
      vecs[2] = make_vec(0,    7,  1'b0, 0,    0,    0,    0, 0, 0, 0, 0, 0);
      vecs[3] = make_vec(0,    99, 1'b1, 2,    4,    6,    0, 1, 2, 1, 1, 1);
      vecs[4] = make_vec(500,  3,  1'b0, 499,  498,  497,  1, 2, 3, 1, 1, 1);

      rst = 1'b1; enable_i = 1'b0; load_i = 1'b0;
      init_alt_i = '0; target_i = '0; motor_i = 1'b0;
      repeat (2) @(negedge clk);
      rst = 1'b0;
      @(negedge clk);
      check("rst_alt",    32'(altimetre_o),         32'd0);
      check("rst_gnss",   32'(gnss_o),              32'd0);
      check("rst_target", 32'(hedef_yukseklik_o),   32'd0);
      check("rst_strobe", 32'(yukseklik_bilgisi_o), 32'd0);
      check("rst_air",    32'(airborne_o),          32'd0);

      // Climb from ground out of reset.
      enable_i = 1'b1; motor_i = 1'b1;
      sb.push_back(mk(2, 0, 1'b1));
      sb.push_back(mk(4, 1, 1'b1));
      sb.push_back(mk(6, 2, 1'b1));
      wait_strobe("t1_s1", n); check("t1_first_latency", 32'(n), 32'(DIV + 1));
      wait_strobe("t1_s2", n); check("t1_interval2", 32'(n), 32'(DIV));
      wait_strobe("t1_s3", n); check("t1_interval3", 32'(n), 32'(DIV));

      // Load/fly vectors: saturation, landing, idle ground, takeoff, descent.
      for (int i = 0; i < 5; i++) begin
         do_load(int'(vecs[i].init_alt), int'(vecs[i].target), vecs[i].motor);
         check("load_alt",    32'(altimetre_o),         32'(vecs[i].init_alt));
         check("load_target", 32'(hedef_yukseklik_o),   32'(vecs[i].target));
         check("load_gnss",   32'(gnss_o),              32'd0);
         check("load_strobe", 32'(yukseklik_bilgisi_o), 32'd0);
         for (int k = 0; k < 3; k++)
            sb.push_back(mk(int'(vecs[i].exp_alt[k]), int'(vecs[i].exp_gnss[k]),
                            vecs[i].exp_air[k]));
         for (int k = 0; k < 3; k++) begin
            wait_strobe("vec", n);
            check("vec_interval", 32'(n), 32'(DIV));
         end
      end

      // Load on the tick cycle: load wins, no strobe, prescaler restarts.
      motor_i = 1'b1;
      repeat (DIV - 1) @(negedge clk);
      do_load(100, 9, 1'b1);
      check("t4_alt",    32'(altimetre_o),         32'd100);
      check("t4_strobe", 32'(yukseklik_bilgisi_o), 32'd0);
      check("t4_target", 32'(hedef_yukseklik_o),   32'd9);
      sb.push_back(mk(102, 1, 1'b1));
      wait_strobe("t4_next", n); check("t4_next_latency", 32'(n), 32'(DIV));

      // Disable mid-flight: outputs freeze, prescaler restarts on re-enable.
      do_load(50, 12, 1'b1);
      enable_i = 1'b0;
      for (int k = 0; k < 10; k++) begin
         @(negedge clk);
         check("t5_hold_alt",    32'(altimetre_o),         32'd50);
         check("t5_hold_strobe", 32'(yukseklik_bilgisi_o), 32'd0);
      end
      check("t5_idle_air",  32'(airborne_o), 32'd0);
      check("t5_hold_gnss", 32'(gnss_o),     32'd0);
      enable_i = 1'b1;
      sb.push_back(mk(52, 1, 1'b1));
      wait_strobe("t5_resume", n); check("t5_resume_latency", 32'(n), 32'(DIV + 1));

      // Reset mid-flight overrides every other input.
      do_load(286, 33, 1'b1);
      for (int k = 1; k <= 7; k++) sb.push_back(mk(286 + 2 * k, k, 1'b1));
      for (int k = 0; k < 7; k++) wait_strobe("t6_fly", n);
      check("t6_pre_alt",  32'(altimetre_o), 32'd300);
      check("t6_pre_gnss", 32'(gnss_o),      32'd7);
      rst = 1'b1; load_i = 1'b1; init_alt_i = 10'd5; target_i = 7'd3;
      enable_i = 1'b1; motor_i = 1'b1;
      @(negedge clk);
      check("t6_alt",    32'(altimetre_o),         32'd0);
      check("t6_gnss",   32'(gnss_o),              32'd0);
      check("t6_target", 32'(hedef_yukseklik_o),   32'd0);
      check("t6_strobe", 32'(yukseklik_bilgisi_o), 32'd0);
      check("t6_air",    32'(airborne_o),          32'd0);
      rst = 1'b0; load_i = 1'b0; enable_i = 1'b0;
      repeat (2 * DIV) @(negedge clk);
      check("t6_post_alt", 32'(altimetre_o), 32'd0);

      check("sb_empty", 32'(sb.size()), 32'd0);
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
